// File: rtl/pim_isa_pkg.sv
// PIM ISA definitions shared by the dispatcher: opcodes, instruction field positions,
// dispatcher state encoding and the opcode classification record.
package pim_isa_pkg;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_MUL   = 6'h02;
    localparam logic [5:0] OP_EAST  = 6'h05;
    localparam logic [5:0] OP_WEST  = 6'h06;
    localparam logic [5:0] OP_SOUTH = 6'h07;
    localparam logic [5:0] OP_NORTH = 6'h08;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // Instruction word layout: opcode | rd | rs1 | rs2 | (unused low bits)
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_FIRE   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;

    typedef struct packed {
        logic is_issue;
        logic is_halt;
        logic is_illegal;
    } op_class_t;

endpackage

// File: rtl/pim_op_classify.sv
// Combinational opcode classifier: exactly one of issue/halt/illegal is set per opcode.
module pim_op_classify
    import pim_isa_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL,
            OP_EAST, OP_WEST, OP_SOUTH, OP_NORTH: cls.is_issue = 1'b1;
            OP_HALT:                              cls.is_halt  = 1'b1;
            default:                              cls.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pim_instr_dispatcher.sv
// Program sequencer for the bit-sliced PIM controller: fetch, decode, load, fire, wait.
// Optional watchdog on the WAIT state is enabled with `define PIM_DISPATCH_WDOG_EN.
module pim_instr_dispatcher
    import pim_isa_pkg::*;
#(
    parameter int IMEM_AW = 10,
    parameter int LENGTH  = 32,
    parameter int TIMEOUT = LENGTH * 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [IMEM_AW-1:0] base_pc,
    output logic               imem_rd_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        ctrl_instr,
    output logic               ctrl_rst_n,
    output logic               ctrl_start,
    input  logic               ctrl_done,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [IMEM_AW-1:0] pc,
`ifdef PIM_DISPATCH_WDOG_EN
    output logic               timeout_err,
`endif
    output logic [15:0]        instr_count
);

    logic [2:0] state;
    logic       wait_arm;
    op_class_t  cls;

`ifdef PIM_DISPATCH_WDOG_EN
    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [WDW-1:0] wdog;
`endif

    pim_op_classify u_classify (
        .opcode (imem_rdata[OPC_HI:OPC_LO]),
        .cls    (cls)
    );

    assign imem_rd_en = (state == S_FETCH);
    assign imem_addr  = pc;
    assign ctrl_rst_n = (state != S_LOAD);
    assign ctrl_start = (state == S_FIRE);
    assign halted     = (state == S_HALTED);
    assign busy       = (state != S_IDLE) && (state != S_HALTED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            ctrl_instr  <= '0;
            illegal     <= 1'b0;
            instr_count <= '0;
            wait_arm    <= 1'b0;
`ifdef PIM_DISPATCH_WDOG_EN
            timeout_err <= 1'b0;
            wdog        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (run) begin
                        pc          <= base_pc;
                        illegal     <= 1'b0;
                        instr_count <= '0;
`ifdef PIM_DISPATCH_WDOG_EN
                        timeout_err <= 1'b0;
`endif
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ctrl_instr <= imem_rdata;
                    if (cls.is_halt) begin
                        state <= S_HALTED;
                    end else if (cls.is_illegal) begin
                        illegal <= 1'b1;
                        pc      <= pc + 1'b1;
                        state   <= S_FETCH;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: state <= S_FIRE;
                S_FIRE: begin
                    if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
                    wait_arm <= 1'b0;
`ifdef PIM_DISPATCH_WDOG_EN
                    wdog     <= '0;
`endif
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A done seen on the first WAIT cycle belongs to the previous op.
                    wait_arm <= 1'b1;
                    if (wait_arm && ctrl_done) begin
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end
`ifdef PIM_DISPATCH_WDOG_EN
                    else if (wdog == WDW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_HALTED;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
